// File: rtl/note_disp_pkg.sv
// note_disp_pkg: shared types, name-code table and tuning-flag helper for the note display.
package note_disp_pkg;
  typedef enum logic [1:0] {BLANK, ACQUIRE, LOCKED} state_t;
  localparam logic [15:0] BLANK_FIELD = 16'h0000;
  localparam logic [3:0] NAME_INVALID = 4'd12;
  localparam logic [95:0] NAME_TAB = {8'hB0, 8'hA7, 8'hA0, 8'h97, 8'h90, 8'hF7,
                                      8'hF0, 8'hE0, 8'hD7, 8'hD0, 8'hC7, 8'hC0};
  function automatic logic [7:0] name_code(input logic [3:0] n);
    return n < NAME_INVALID ? NAME_TAB[{n, 3'b000} +: 8] : 8'h00;
  endfunction
  function automatic logic [3:0] tune_flag(input logic [7:0] cents, input logic [7:0] tol);
    logic signed [8:0] c, t;
    c = {cents[7], cents};
    t = {1'b0, tol};
    return c > t ? 4'h1 : c < -t ? 4'hF : 4'h0;
  endfunction
endpackage

// File: rtl/note_chan_tracker.sv
// note_chan_tracker: one channel's acquire/lock FSM, match counter and blanking timeout.
module note_chan_tracker
  import note_disp_pkg::*;
#(
  parameter int HOLD_CNT = 4,
  parameter int unsigned TIMEOUT = 27'd67_500_000,
  parameter logic [7:0] TOL = 8'd10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [3:0]  name,
  input  logic [3:0]  octave,
  input  logic [7:0]  cents,
  output logic [15:0] field,
  output logic        changed
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [3:0] cname, cname_n, coct, coct_n;
  logic [7:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0] field_n;
  logic match;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= BLANK;
      cname   <= '0;
      coct    <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      field   <= BLANK_FIELD;
      changed <= 1'b0;
    end else begin
      state   <= state_n;
      cname   <= cname_n;
      coct    <= coct_n;
      cnt     <= cnt_n;
      tcnt    <= tcnt_n;
      field   <= field_n;
      changed <= field_n != field;
    end
  end
  // A sample always clears the timeout, so it wins over a same-cycle expiry.
  always_comb begin
    state_n = state;
    cname_n = cname;
    coct_n  = coct;
    cnt_n   = cnt;
    field_n = field;
    match   = state != BLANK && name == cname && octave == coct;
    tcnt_n  = valid ? '0 : tcnt == TW'(TIMEOUT) ? tcnt : tcnt + 1'b1;
    if (valid && name >= NAME_INVALID) begin
      state_n = BLANK;
      cnt_n   = '0;
      field_n = BLANK_FIELD;
    end else if (valid && state == LOCKED && match) begin
      field_n[15:12] = tune_flag(cents, TOL);
    end else if (valid) begin
      cname_n = name;
      coct_n  = octave;
      cnt_n   = (state == ACQUIRE && match) ? cnt + 8'd1 : 8'd1;
      state_n = cnt_n == 8'(HOLD_CNT) ? LOCKED : ACQUIRE;
      field_n = cnt_n == 8'(HOLD_CNT) ? {tune_flag(cents, TOL), name_code(name), octave} : field;
    end else if (tcnt >= TW'(TIMEOUT - 1)) begin
      state_n = BLANK;
      cnt_n   = '0;
      field_n = BLANK_FIELD;
    end
  end
endmodule

// File: rtl/note_display_ctrl.sv
// note_display_ctrl: multi-channel note tracker feeding a 64-bit hex display word.
// Optional flag blinking is enabled with NOTE_DISP_BLINK_EN.
module note_display_ctrl
  import note_disp_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int HOLD_CNT = 4,
  parameter int unsigned TIMEOUT = 27'd67_500_000,
  parameter logic [7:0] TOL = 8'd10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        note_valid,
  input  logic [1:0]  note_ch,
  input  logic [3:0]  note_name,
  input  logic [3:0]  note_octave,
  input  logic [7:0]  note_cents,
  output logic [63:0] data,
  output logic        update
);
  logic [15:0] fld [4];
  logic chg [4];
  logic [3:0] flag_mask;
`ifdef NOTE_DISP_BLINK_EN
  logic [22:0] blink_cnt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) blink_cnt <= '0;
    else blink_cnt <= blink_cnt + 1'b1;
  end
  assign flag_mask = {4{~blink_cnt[22]}};
`else
  assign flag_mask = 4'hF;
`endif
  for (genvar i = 0; i < 4; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      note_chan_tracker #(
        .HOLD_CNT(HOLD_CNT),
        .TIMEOUT (TIMEOUT),
        .TOL     (TOL)
      ) u_trk (
        .clock  (clock),
        .reset_n(reset_n),
        .valid  (note_valid && note_ch == 2'(i)),
        .name   (note_name),
        .octave (note_octave),
        .cents  (note_cents),
        .field  (fld[i]),
        .changed(chg[i])
      );
    end else begin : g_off
      assign fld[i] = BLANK_FIELD;
      assign chg[i] = 1'b0;
    end
    assign data[16*i +: 16] = {fld[i][15:12] & flag_mask, fld[i][11:0]};
  end
  assign update = chg[0] | chg[1] | chg[2] | chg[3];
endmodule
